// File: rtl/lea_pkg.sv
// Shared definitions for the LEA serial add/sub datapath.
package lea_pkg;

    localparam int unsigned LEA_WORD_W = 32;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } lea_state_t;

endpackage

// File: rtl/lea_chunk_addsub.sv
// One CHUNK-bit slice of a lane: add, or subtract via inverted B with carry-in.
module lea_chunk_addsub
    import lea_pkg::*;
#(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK-1:0] b_eff;

    assign b_eff = (mode == MODE_ADD) ? b : ~b;
    assign {cout, s} = (CHUNK+1)'(a) + (CHUNK+1)'(b_eff) + (CHUNK+1)'(cin);

endmodule

// File: rtl/lea_serial_addsub.sv
// Multi-lane modular adder/subtractor working CHUNK bits per cycle, LSB first,
// with a registered carry/borrow chaining the slices of each lane.
module lea_serial_addsub
    import lea_pkg::*;
#(
    parameter int unsigned WIDTH = LEA_WORD_W,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic                   Mode,
    input  logic [LANES*WIDTH-1:0] A,
    input  logic [LANES*WIDTH-1:0] B,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [LANES*WIDTH-1:0] Result,
    output logic [LANES-1:0]       Carry,
    output logic                   Busy
);

    localparam int unsigned CHUNK_NZ = (CHUNK == 0) ? 1 : CHUNK;
    localparam int unsigned NCHUNK   = WIDTH / CHUNK_NZ;
    localparam int unsigned CNT_W    = $clog2(NCHUNK) + 1;
    localparam int unsigned IDX_W    = $clog2(WIDTH) + 1;

    if (CHUNK == 0 || (WIDTH % CHUNK_NZ) != 0) begin : g_bad_cfg
        $error("lea_serial_addsub: WIDTH must be a nonzero multiple of CHUNK");
    end

    lea_state_t                   state;
    logic [CNT_W-1:0]             cnt;
    logic                         mode_q;
    logic [LANES-1:0][WIDTH-1:0]  a_q;
    logic [LANES-1:0][WIDTH-1:0]  b_q;
    logic [LANES-1:0][WIDTH-1:0]  res_w;
    logic [LANES-1:0][WIDTH-1:0]  res_nxt;
    logic [LANES-1:0]             c_q;
    logic [LANES-1:0]             cout_v;
    logic [LANES-1:0][CHUNK-1:0]  s_v;
    logic [IDX_W-1:0]             base;

    assign base = IDX_W'(cnt) * IDX_W'(CHUNK);

    // One slice adder per lane; lanes never share a carry.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lea_chunk_addsub #(.CHUNK(CHUNK)) u_slice (
            .a    (a_q[l][base +: CHUNK]),
            .b    (b_q[l][base +: CHUNK]),
            .mode (mode_q),
            .cin  (c_q[l]),
            .s    (s_v[l]),
            .cout (cout_v[l])
        );
    end

    // Working result with the current slice merged in.
    always_comb begin
        res_nxt = res_w;
        for (int l = 0; l < LANES; l++) begin
            res_nxt[l][base +: CHUNK] = s_v[l];
        end
    end

    // Control FSM; Result/Carry only load on the final slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            In_Ready  <= 1'b1;
            Out_Valid <= 1'b0;
            Busy      <= 1'b0;
            Result    <= '0;
            Carry     <= '0;
            cnt       <= '0;
            mode_q    <= MODE_ADD;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            res_w     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (In_Valid && In_Ready) begin
                        a_q      <= A;
                        b_q      <= B;
                        mode_q   <= Mode;
                        c_q      <= {LANES{Mode}};
                        cnt      <= '0;
                        In_Ready <= 1'b0;
                        Busy     <= 1'b1;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    res_w <= res_nxt;
                    c_q   <= cout_v;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NCHUNK - 1)) begin
                        Result    <= res_nxt;
                        Carry     <= (mode_q == MODE_SUB) ? ~cout_v : cout_v;
                        Out_Valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        In_Ready  <= 1'b1;
                        Busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    Out_Valid <= 1'b0;
                    In_Ready  <= 1'b1;
                    Busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lea_serial_addsub.sv
// Bench for lea_serial_addsub: three instances (CHUNK 8, 1, 32) share stimulus.
module tb_lea_serial_addsub;

    localparam int unsigned W  = 32;
    localparam int unsigned L  = 4;
    localparam int unsigned NI = 3;
    localparam int unsigned BW = W * L;

    typedef struct {
        logic          mode;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] r;
        logic [L-1:0]  c;
    } vec_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          mode      = 1'b0;
    logic          out_ready = 1'b0;
    logic [BW-1:0] a         = '0;
    logic [BW-1:0] b         = '0;

    logic [NI-1:0] ir;
    logic [NI-1:0] ov;
    logic [NI-1:0] bsy;
    logic [BW-1:0] res [NI];
    logic [L-1:0]  car [NI];

    int checks = 0;
    int errors = 0;
    int nch [NI] = '{4, 32, 1};

    always #5 clk = ~clk;

    lea_serial_addsub #(.WIDTH(W), .CHUNK(8), .LANES(L)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .In_Valid(in_valid), .In_Ready(ir[0]), .Mode(mode),
        .A(a), .B(b), .Out_Valid(ov[0]), .Out_Ready(out_ready),
        .Result(res[0]), .Carry(car[0]), .Busy(bsy[0])
    );

    lea_serial_addsub #(.WIDTH(W), .CHUNK(1), .LANES(L)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .In_Valid(in_valid), .In_Ready(ir[1]), .Mode(mode),
        .A(a), .B(b), .Out_Valid(ov[1]), .Out_Ready(out_ready),
        .Result(res[1]), .Carry(car[1]), .Busy(bsy[1])
    );

    lea_serial_addsub #(.WIDTH(W), .CHUNK(32), .LANES(L)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .In_Valid(in_valid), .In_Ready(ir[2]), .Mode(mode),
        .A(a), .B(b), .Out_Valid(ov[2]), .Out_Ready(out_ready),
        .Result(res[2]), .Carry(car[2]), .Busy(bsy[2])
    );

    // Reference: per-lane (A op B) mod 2^W with carry-out / unsigned borrow.
    function automatic void model(input logic m, input logic [BW-1:0] x, input logic [BW-1:0] y,
                                  output logic [BW-1:0] r, output logic [L-1:0] c);
        for (int l = 0; l < L; l++) begin
            logic [W-1:0] xa;
            logic [W-1:0] ya;
            logic [63:0]  sum;
            xa = x[l*W +: W];
            ya = y[l*W +: W];
            if (m) begin
                r[l*W +: W] = xa - ya;
                c[l]        = (xa < ya);
            end else begin
                sum         = 64'(xa) + 64'(ya);
                r[l*W +: W] = sum[W-1:0];
                c[l]        = sum[W];
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One transaction on all instances; checks latency, result, carry and hold stability.
    task automatic run_txn(input string nm, input logic m, input logic [BW-1:0] x,
                           input logic [BW-1:0] y, input logic [BW-1:0] er, input logic [L-1:0] ec);
        int            lat  [NI];
        logic [BW-1:0] rcap [NI];
        logic [L-1:0]  ccap [NI];
        logic          done;
        for (int i = 0; i < NI; i++) begin
            lat[i]  = -1;
            rcap[i] = 'x;
            ccap[i] = 'x;
        end
        @(negedge clk);
        chk($sformatf("%s in_ready", nm), BW'(ir), BW'({NI{1'b1}}));
        mode = m; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            @(posedge clk); #1;
            done = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (lat[i] < 0 && ov[i]) begin
                    lat[i]  = cyc;
                    rcap[i] = res[i];
                    ccap[i] = car[i];
                end
                if (lat[i] < 0) done = 1'b0;
            end
            if (done) break;
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s c%0d latency", nm, nch[i]), BW'(lat[i]), BW'(nch[i]));
            chk($sformatf("%s c%0d result", nm, nch[i]), rcap[i], er);
            chk($sformatf("%s c%0d carry", nm, nch[i]), BW'(ccap[i]), BW'(ec));
            chk($sformatf("%s c%0d held", nm, nch[i]), res[i], er);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("%s out_valid drop", nm), BW'(ov), BW'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t          tbl [5];
        logic [BW-1:0] x1, y1, e1, x2, y2, e2, xr, yr, er;
        logic [L-1:0]  c1, c2, cr;
        logic          mr, stale;

        tbl[0] = '{1'b1, {32'h0, 32'h0, 32'h0, 32'hA3F37AF8}, {32'h0, 32'h0, 32'h0, 32'h5BF75DF3},
                   {32'h0, 32'h0, 32'h0, 32'h47FC1D05}, 4'b0000};
        tbl[1] = '{1'b1, {32'h0, 32'h0, 32'h0, 32'h00000000}, {32'h0, 32'h0, 32'h0, 32'h00000001},
                   {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 4'b0001};
        tbl[2] = '{1'b0, {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, {32'h0, 32'h0, 32'h0, 32'h00000001},
                   {32'h0, 32'h0, 32'h0, 32'h00000000}, 4'b0001};
        tbl[3] = '{1'b1, {32'h00000001, 32'h12345678, 32'h00000005, 32'h6AA7391A},
                   {32'h80000000, 32'h12345678, 32'h00000003, 32'h07F9804D},
                   {32'h80000001, 32'h00000000, 32'h00000002, 32'h62ADB8CD}, 4'b1000};
        tbl[4] = '{1'b0, {32'h80000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF},
                   {32'h80000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF},
                   {32'h00000000, 32'h00000000, 32'h00000002, 32'hFFFFFFFE}, 4'b1001};

        // Reset state while rst_n is held low.
        #12;
        chk("reset in_ready", BW'(ir), BW'({NI{1'b1}}));
        chk("reset out_valid", BW'(ov), BW'(0));
        chk("reset busy", BW'(bsy), BW'(0));
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset c%0d result", nch[i]), res[i], '0);
            chk($sformatf("reset c%0d carry", nch[i]), BW'(car[i]), BW'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            run_txn($sformatf("vec%0d", t), tbl[t].mode, tbl[t].a, tbl[t].b, tbl[t].r, tbl[t].c);
        end

        // Backpressure: new operands offered while the result sits in HOLD.
        x1 = {32'h11111111, 32'hDEADBEEF, 32'h0000FFFF, 32'h7FFFFFFF};
        y1 = {32'h22222222, 32'h01234567, 32'h00000001, 32'h00000001};
        x2 = {32'h00000010, 32'hCAFEF00D, 32'h55555555, 32'h00000003};
        y2 = {32'h00000020, 32'h0000F00D, 32'hAAAAAAAA, 32'h00000003};
        model(1'b0, x1, y1, e1, c1);
        model(1'b1, x2, y2, e2, c2);
        @(negedge clk);
        mode = 1'b0; a = x1; b = y1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp first valid", BW'(ov[0]), BW'(1));
        chk("bp first result", res[0], e1);
        mode = 1'b1; a = x2; b = y2; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d valid", k), BW'(ov[0]), BW'(1));
            chk($sformatf("bp hold%0d in_ready", k), BW'(ir[0]), BW'(0));
            chk($sformatf("bp hold%0d result", k), res[0], e1);
            chk($sformatf("bp hold%0d carry", k), BW'(car[0]), BW'(c1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp idle valid", BW'(ov[0]), BW'(0));
        chk("bp idle in_ready", BW'(ir[0]), BW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp accept busy", BW'(bsy[0]), BW'(1));
        chk("bp accept in_ready", BW'(ir[0]), BW'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("bp early valid", BW'(ov[0]), BW'(0));
        @(posedge clk); #1;
        chk("bp second valid", BW'(ov[0]), BW'(1));
        chk("bp second result", res[0], e2);
        chk("bp second carry", BW'(car[0]), BW'(c2));
        out_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (ir == {NI{1'b1}}) break;
        end
        out_ready = 1'b0;
        chk("bp drained", BW'(ir), BW'({NI{1'b1}}));

        // Asynchronous reset while the CHUNK=8 instance works on slice 2.
        @(negedge clk);
        mode = 1'b0; a = x1; b = y1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", BW'(ov), BW'(0));
        chk("rst in_ready", BW'(ir), BW'({NI{1'b1}}));
        chk("rst busy", BW'(bsy), BW'(0));
        chk("rst result", res[0], '0);
        chk("rst carry", BW'(car[0]), BW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ov != '0 || ir != {NI{1'b1}}) stale = 1'b1;
        end
        chk("rst no stale valid", BW'(stale), BW'(0));

        // Random vectors against the reference model.
        for (int n = 0; n < 1000; n++) begin
            mr = 1'($urandom_range(0, 1));
            for (int l = 0; l < L; l++) begin
                xr[l*W +: W] = $urandom;
                yr[l*W +: W] = $urandom;
            end
            if (n % 50 == 0) yr = xr;
            model(mr, xr, yr, er, cr);
            run_txn($sformatf("rand%0d", n), mr, xr, yr, er, cr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lea_serial_addsub.md
Name: lea_serial_addsub

Overview:
- Next-generation LEA word arithmetic unit. Parametrised, multi-lane modular adder/subtractor for the encrypt (add) and decrypt (sub) round datapaths.
- Processes each WIDTH-bit lane in CHUNK-bit slices, LSB first, over WIDTH/CHUNK cycles. A registered carry/borrow links the slices, which trades latency for adder area.
- Uses valid/ready handshakes on both sides. Reports per-lane carry-out/borrow-out, which the single-cycle combinational subtractor did not provide.

Parameters:
- WIDTH, 32, lane word width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle per lane; 1..WIDTH.
- LANES, 4, number of independent lanes sharing one handshake and one Mode.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- In_Valid  in  1  operand set valid
- In_Ready  out  1  block can accept operands
- Mode  in  1  0 = add (A+B), 1 = sub (A-B); sampled on input handshake
- A  in  LANES*WIDTH  minuend/augend; lane i = A[i*WIDTH +: WIDTH]
- B  in  LANES*WIDTH  subtrahend/addend, same packing
- Out_Valid  out  1  Result/Carry valid
- Out_Ready  in  1  consumer accepts result
- Result  out  LANES*WIDTH  (A op B) mod 2^WIDTH per lane
- Carry  out  LANES  add: carry-out; sub: borrow-out (1 iff A<B unsigned)
- Busy  out  1  high in CALC or HOLD

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0 and after it: state=IDLE, In_Ready=1, Out_Valid=0, Busy=0, Result=0, Carry=0, chunk counter=0, operand registers=0.
- Reset mid-operation or in HOLD aborts immediately. The pending result is discarded and never presented.
- FSM has three states: IDLE, CALC, HOLD.
- IDLE:
  - In_Ready=1.
  - On In_Valid & In_Ready: latch A, B and Mode; set per-lane carry register to Mode; clear counter; go to CALC.
  - In_Valid with unknown operands while not in IDLE has no effect.
- CALC:
  - In_Ready=0.
  - Each cycle, for chunk k = counter and each lane: {c_out, s} = A_k + (B_k XOR {CHUNK{Mode}}) + c_reg.
  - s is written to result slice k; c_reg is updated to c_out; counter increments.
  - After the chunk at k = NCHUNK-1 (NCHUNK = WIDTH/CHUNK), go to HOLD.
  - Result and Carry outputs are updated only on the CALC->HOLD edge. Mid-calculation partials are never visible on the outputs.
  - Carry = c_out for add, ~c_out for sub.
- HOLD:
  - Out_Valid=1. Result and Carry stay stable until Out_Valid & Out_Ready.
  - On that handshake, go to IDLE; Out_Valid=0 from the next cycle. Result and Carry keep their last value.
  - In_Ready=0 in HOLD. There is no same-cycle accept with the output handshake.
- Latency and throughput:
  - The input handshake at edge 0 gives Out_Valid=1 after edge NCHUNK.
  - With Out_Ready tied high, a new operand set is accepted every NCHUNK+2 cycles.
- Edge case CHUNK=WIDTH: NCHUNK=1, one CALC cycle.
- Arithmetic is modulo 2^WIDTH with no saturation. Lanes are fully independent; a carry never crosses a lane boundary.
- Counter width is $clog2(NCHUNK)+1; it never wraps within an operation.
- Elaboration error if WIDTH % CHUNK != 0 or CHUNK == 0.

Decomposition:
- Shared package lea_pkg holds:
  - MODE_ADD=1'b0 and MODE_SUB=1'b1
  - the FSM state encoding (IDLE/CALC/HOLD)
  - LEA_WORD_W=32
- Sub-module lea_chunk_addsub: combinational CHUNK-bit slice with inputs a, b, mode, cin and outputs s, cout. It is instantiated LANES times in the top; the top owns the FSM, counter, operand and result registers.

Test Plan:
- Directed sub:
  - Stimulus: WIDTH=32, CHUNK=8, LANES=1; Mode=1, A=0xA3F37AF8, B=0x5BF75DF3.
  - Required response: Out_Valid exactly 4 cycles after accept; Result=0x47FC1D05, Carry=0.
- Wrap/borrow:
  - Stimulus: Mode=1, A=0x00000000, B=0x00000001.
  - Required response: Result=0xFFFFFFFF, Carry=1.
  - Stimulus: Mode=0, A=0xFFFFFFFF, B=0x00000001.
  - Required response: Result=0x00000000, Carry=1.
- Multi-lane:
  - Stimulus: LANES=4; lane0 sub 0x6AA7391A-0x07F9804D, lane1 add 0x00000001+0x00000001 in a separate transaction, lane2 A=B, lane3 A<B.
  - Required response: lane0=0x62ADB8CD with borrow 0; lane2=0 with borrow 0; lane3 borrow 1; no cross-lane carry.
- Backpressure:
  - Stimulus: hold Out_Ready=0 for 5 cycles in HOLD while In_Valid=1 with new operands.
  - Required response: Out_Valid stays 1; Result stable; In_Ready=0; new operands not taken. They are accepted in IDLE after the output handshake.
- Reset mid-CALC:
  - Stimulus: drop rst_n asynchronously at chunk 2.
  - Required response: immediately Out_Valid=0, Result=0, In_Ready=1 after release; no stale Out_Valid ever appears.
- Latency sweep:
  - Stimulus: CHUNK in {1, 8, 32}.
  - Required response: Out_Valid after 32 / 4 / 1 cycles respectively; results match a reference (A±B) mod 2^32 over 1000 random vectors.
